// File: rtl/emg_pkg.sv
// emg_pkg: shared state encoding and counter widths for the EMG frame packer
package emg_pkg;
  typedef enum logic [1:0] {SYNC, FILL, DRAIN} state_t;
  localparam int SEQ_W = 8;
  localparam int DROP_W = 8;
endpackage

// File: rtl/emg_slot_buffer.sv
// emg_slot_buffer: one-write, one-registered-read sample store indexed by slot
module emg_slot_buffer #(
  parameter int Depth = 16,
  parameter int Aw = 4,
  parameter int Dw = 12
) (
  input  logic          Clk,
  input  logic          wr_en,
  input  logic [Aw-1:0] wr_addr,
  input  logic [Dw-1:0] wr_data,
  input  logic [Aw-1:0] rd_addr,
  output logic [Dw-1:0] rd_data
);
  logic [Dw-1:0] mem [Depth];
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/emg_frame_packer.sv
// emg_frame_packer: collects slot-ordered EMG samples into a frame and streams
// it out as a sequence-number header followed by the samples
module emg_frame_packer import emg_pkg::*; #(
  parameter int Max_Count = 15,
  parameter int Bits = 4,
  parameter int Data_W = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [Bits-1:0]   Slot,
  input  logic [Data_W-1:0] Sample,
  input  logic              Sample_Valid,
  output logic [Data_W-1:0] Out_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              Out_First,
  output logic              Out_Last,
  output logic              Sync_Err,
  output logic [DROP_W-1:0] Drop_Count
);
  localparam logic [Bits-1:0] LAST = Bits'(Max_Count);
  state_t state, state_nxt;
  logic [Bits-1:0] exp_slot, rd_ptr, rd_addr;
  logic [SEQ_W-1:0] frame_seq;
  logic [Data_W-1:0] rd_data;
  logic xfer, last_xfer, in_order, wr_en;
  emg_slot_buffer #(.Depth(Max_Count + 1), .Aw(Bits), .Dw(Data_W)) u_buf (
    .Clk(Clk), .wr_en(wr_en), .wr_addr(Slot), .wr_data(Sample),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= SYNC;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      SYNC: if (Sample_Valid && Slot == '0) state_nxt = FILL;
      FILL: if (Sample_Valid) state_nxt = in_order ? (Slot == LAST ? DRAIN : FILL) : (Slot == '0 ? FILL : SYNC);
      DRAIN: if (last_xfer) state_nxt = SYNC;
      default: state_nxt = SYNC;
    endcase
  end
  // rd_ptr names the sample sitting in rd_data; advancing on each transfer keeps the next word prefetched
  always_comb begin
    xfer = Out_Valid && Out_Ready;
    last_xfer = xfer && Out_Last;
    in_order = Slot == exp_slot;
    wr_en = Sample_Valid && (state == SYNC ? Slot == '0 : state == FILL && (in_order || Slot == '0));
    rd_addr = state != DRAIN ? '0 : (xfer && rd_ptr != LAST) ? rd_ptr + 1'b1 : rd_ptr;
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Out_Data <= '0;
      Out_Valid <= 1'b0;
      Out_First <= 1'b0;
      Out_Last <= 1'b0;
      Sync_Err <= 1'b0;
      Drop_Count <= '0;
      frame_seq <= '0;
      exp_slot <= '0;
      rd_ptr <= '0;
    end else begin
      Sync_Err <= state == FILL && Sample_Valid && !in_order;
      if (state == DRAIN && Sample_Valid && Drop_Count != '1) Drop_Count <= Drop_Count + 1'b1;
      exp_slot <= state_nxt != FILL ? '0 : wr_en ? Slot + 1'b1 : exp_slot;
      if (state == FILL && state_nxt == DRAIN) begin
        Out_Data <= Data_W'(frame_seq);
        Out_Valid <= 1'b1;
        Out_First <= 1'b1;
        Out_Last <= 1'b0;
        rd_ptr <= '0;
      end else if (last_xfer) begin
        Out_Valid <= 1'b0;
        Out_First <= 1'b0;
        Out_Last <= 1'b0;
        frame_seq <= frame_seq + 1'b1;
        rd_ptr <= '0;
      end else if (xfer) begin
        Out_Data <= rd_data;
        Out_First <= 1'b0;
        Out_Last <= rd_ptr == LAST;
        if (rd_ptr != LAST) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_emg_frame_packer.sv
// tb_emg_frame_packer: directed checks of framing, stalls, sync errors, drops and reset
module tb_emg_frame_packer;
  logic Clk = 1'b0, Reset = 1'b0, Sample_Valid = 1'b0, Out_Ready = 1'b0;
  logic [3:0] Slot = '0;
  logic [11:0] Sample = '0, Out_Data;
  logic Out_Valid, Out_First, Out_Last, Sync_Err;
  logic [7:0] Drop_Count;
  logic [11:0] smp [16];
  int nvec = 0, nerr = 0;
  emg_frame_packer dut (
    .Clk(Clk), .Reset(Reset), .Slot(Slot), .Sample(Sample), .Sample_Valid(Sample_Valid),
    .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_First(Out_First),
    .Out_Last(Out_Last), .Sync_Err(Sync_Err), .Drop_Count(Drop_Count)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic send(input logic [3:0] s, input logic [11:0] d);
    Slot = s;
    Sample = d;
    Sample_Valid = 1'b1;
    tick();
    Sample_Valid = 1'b0;
  endtask
  task automatic fill();
    for (int s = 0; s < 16; s++) send(4'(s), smp[s]);
  endtask
  task automatic drain(input logic [7:0] seq, input bit toggle, input bit drop_last);
    int idx = 0;
    logic [11:0] ew;
    for (int c = 0; c < 100 && idx < 17; c++) begin
      ew = idx == 0 ? {4'h0, seq} : smp[idx-1];
      chk("out_valid", Out_Valid, 1);
      chk("out_data", Out_Data, ew);
      chk("out_first", Out_First, idx == 0);
      chk("out_last", Out_Last, idx == 16);
      Out_Ready = toggle ? !c[0] : 1'b1;
      if (drop_last && idx == 16 && Out_Ready) begin
        Slot = '0;
        Sample = 12'hEEE;
        Sample_Valid = 1'b1;
      end
      tick();
      Sample_Valid = 1'b0;
      if (Out_Ready) idx++;
    end
    chk("drain_done", idx, 17);
    Out_Ready = 1'b0;
    chk("valid_after_frame", Out_Valid, 0);
  endtask
  initial begin
    #2;
    chk("rst_valid", Out_Valid, 0);
    chk("rst_data", Out_Data, 0);
    chk("rst_first", Out_First, 0);
    chk("rst_last", Out_Last, 0);
    chk("rst_sync_err", Sync_Err, 0);
    chk("rst_drop", Drop_Count, 0);
    repeat (2) tick();
    Reset = 1'b1;
    for (int s = 0; s < 16; s++) smp[s] = 12'(s * 16);
    fill();
    drain(8'd0, 1'b0, 1'b0);
    fill();
    drain(8'd1, 1'b1, 1'b0);
    send(4'd0, 12'h111);
    send(4'd1, 12'h222);
    send(4'd2, 12'h333);
    send(4'd5, 12'h444);
    chk("sync_err_gap", Sync_Err, 1);
    tick();
    chk("sync_err_pulse_end", Sync_Err, 0);
    for (int s = 6; s < 16; s++) send(4'(s), 12'h0AB);
    chk("ignored_no_valid", Out_Valid, 0);
    chk("ignored_no_err", Sync_Err, 0);
    for (int s = 0; s < 16; s++) smp[s] = 12'hA00 + 12'(s);
    fill();
    drain(8'd2, 1'b0, 1'b0);
    for (int s = 0; s < 8; s++) send(4'(s), 12'h100 + 12'(s));
    chk("restart_pre_err", Sync_Err, 0);
    send(4'd0, 12'h7FF);
    chk("restart_err", Sync_Err, 1);
    for (int s = 1; s < 16; s++) send(4'(s), 12'h100 + 12'(s));
    for (int s = 0; s < 16; s++) smp[s] = 12'h100 + 12'(s);
    smp[0] = 12'h7FF;
    drain(8'd3, 1'b0, 1'b1);
    chk("drop_on_last", Drop_Count, 1);
    send(4'd1, 12'h001);
    chk("not_captured_a", Sync_Err, 0);
    send(4'd3, 12'h003);
    chk("not_captured_b", Sync_Err, 0);
    chk("not_captured_valid", Out_Valid, 0);
    for (int s = 0; s < 16; s++) smp[s] = 12'h300 + 12'(s);
    fill();
    Slot = '0;
    Sample_Valid = 1'b1;
    repeat (300) tick();
    Sample_Valid = 1'b0;
    chk("drop_saturate", Drop_Count, 255);
    chk("stall_header", Out_Data, 12'h004);
    chk("stall_first", Out_First, 1);
    drain(8'd4, 1'b0, 1'b0);
    for (int s = 0; s < 16; s++) smp[s] = 12'h500 + 12'(s);
    fill();
    Out_Ready = 1'b1;
    repeat (5) tick();
    Out_Ready = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("mid_rst_valid", Out_Valid, 0);
    chk("mid_rst_drop", Drop_Count, 0);
    chk("mid_rst_data", Out_Data, 0);
    chk("mid_rst_last", Out_Last, 0);
    tick();
    Reset = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", Out_Valid, 0);
    for (int s = 0; s < 16; s++) smp[s] = 12'h600 + 12'(s);
    fill();
    drain(8'd0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/emg_frame_packer.md
EMG_FRAME_PACKER -- requirements
Module: emg_frame_packer

Interface
REQ-001 Parameter Max_Count, default 15, highest slot index produced by the upstream slot counter; frame holds Max_Count+1 samples.
REQ-002 Parameter Bits, default 4, width of the slot index; Bits SHALL satisfy 2**Bits > Max_Count.
REQ-003 Parameter Data_W, default 12, sample and output word width; Data_W SHALL be >= 8.
REQ-004 Clk  input  1  single clock; all state on posedge Clk.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Slot  input  Bits  slot index from upstream counter, sampled with Sample_Valid.
REQ-007 Sample  input  Data_W  EMG sample for Slot.
REQ-008 Sample_Valid  input  1  Slot/Sample qualified this cycle; no backpressure upstream.
REQ-009 Out_Data  output  Data_W  frame word.
REQ-010 Out_Valid  output  1  Out_Data valid.
REQ-011 Out_Ready  input  1  downstream accepts; transfer = Out_Valid & Out_Ready.
REQ-012 Out_First  output  1  current word is the header.
REQ-013 Out_Last  output  1  current word is the final sample of the frame.
REQ-014 Sync_Err  output  1  one-cycle pulse on slot-order violation.
REQ-015 Drop_Count  output  8  saturating count of samples dropped while draining.

Function
REQ-016 States SYNC, FILL, DRAIN; reset state SYNC.
REQ-017 SYNC: Sample_Valid with Slot==0 stores sample at index 0, expected slot := 1, go FILL; Sample_Valid with Slot!=0 ignored, no error, no drop count.
REQ-018 FILL: Sample_Valid with Slot==expected stores sample, expected += 1; if Slot==Max_Count, go DRAIN next cycle.
REQ-019 FILL: Sample_Valid with Slot!=expected pulses Sync_Err next cycle; if Slot==0, frame restarts (sample stored at index 0, expected := 1, stay FILL); otherwise go SYNC, partial frame discarded.
REQ-020 DRAIN: Out_Valid high from first cycle in DRAIN until last transfer; frame = header word then Max_Count+1 samples in slot order.
REQ-021 Header word = Frame_Seq (8 bits) zero-extended to Data_W, Out_First=1; Out_Last=1 only on slot Max_Count word.
REQ-022 Out_Data, Out_First, Out_Last SHALL hold stable while Out_Valid & !Out_Ready.
REQ-023 Transfer of the Out_Last word: Out_Valid low next cycle, Frame_Seq += 1 (wraps 255->0), state -> SYNC.
REQ-024 DRAIN: every Sample_Valid is dropped; Drop_Count += 1, saturating at 255; never cleared except by reset.
REQ-025 Sample_Valid with Slot==0 in the same cycle as the Out_Last transfer SHALL be dropped (counted), not captured.
REQ-026 Min latency: last sample accepted at cycle N -> header on Out_Data with Out_Valid at N+1; with Out_Ready held high, Out_Last at N+Max_Count+2.
REQ-027 Slot values > Max_Count are treated as order violations per REQ-019 in FILL and ignored in SYNC.

Reset
REQ-028 Reset low asynchronously forces: state SYNC, Out_Valid 0, Out_First 0, Out_Last 0, Out_Data 0, Sync_Err 0, Drop_Count 0, Frame_Seq 0, expected slot 0.
REQ-029 Buffer contents need not be reset; reset mid-DRAIN aborts the frame with no further Out_Valid until a new full frame is filled.
REQ-030 Reset deassertion is synchronized externally; first capture possible on the first posedge after release.

Structure
REQ-031 Shared package emg_pkg holds the state enum (SYNC/FILL/DRAIN) and constant SEQ_W=8, DROP_W=8.
REQ-032 Sample storage SHALL be a sub-module emg_slot_buffer (Max_Count+1 x Data_W, one write port, one registered read port); read address prefetch keeps REQ-026 timing.

Verification
REQ-033 Reset release, slots 0..15 with Sample=slot*16, Out_Ready=1 -> header 0x000 (First), then 0x000..0x0F0, Last on 0x0F0, Frame_Seq then 1.
REQ-034 Full frame, Out_Ready toggled 1/0 each cycle -> 17 transfers, identical data/flags to REQ-033, outputs stable on stalled cycles.
REQ-035 Slots 0,1,2,5 -> Sync_Err pulse one cycle after slot 5, state SYNC; following slots 6..15 ignored; next slot 0 starts clean frame.
REQ-036 Slots 0..7 then slot 0 -> Sync_Err pulse, frame restarts; slots 1..15 complete frame with new slot-0 sample.
REQ-037 Out_Ready=0 during DRAIN, 300 Sample_Valid pulses -> Drop_Count saturates at 255, frame data intact afterwards.
REQ-038 Reset asserted after 5th output transfer -> Out_Valid 0 immediately, Drop_Count 0, header of next frame = 0x000.
